// File: rtl/tank_state_uart_tx.sv
// Serialises the local tank x/y/direction into a framed UART 8N1 packet once per vsync rise.
// Optional macro TANK_TX_CHECKSUM_EN appends an XOR checksum byte (5-byte packet instead of 4).
module tank_state_uart_tx #(
    parameter int unsigned CLK_FREQ  = 65000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       tx_en,
    input  logic [9:0] xpos_tank,
    input  logic [9:0] ypos_tank,
    input  logic [1:0] direction_tank,
    output logic       tx,
    output logic       busy,
    output logic       pkt_done
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef TANK_TX_CHECKSUM_EN
    localparam int unsigned NBYTES = 5;
`else
    localparam int unsigned NBYTES = 4;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]       BYTE_LAST = 3'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic             pending_q, pending_d;
    logic             vsync_q;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [1:0]       dir_q, dir_d;

    logic       trig;
    logic       bit_end;
    logic [7:0] cur_byte;
    logic [7:0] b1, b2, b3;

    assign trig    = vsync && !vsync_q && tx_en;
    assign bit_end = (cnt_q == CNT_LAST);

    assign b1 = x_q[7:0];
    assign b2 = {y_q[5:0], x_q[9:8]};
    assign b3 = {dir_q, 2'b00, y_q[9:6]};

    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
`ifdef TANK_TX_CHECKSUM_EN
            default: cur_byte = b1 ^ b2 ^ b3;
`else
            default: cur_byte = '1;
`endif
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            pending_q <= 1'b0;
            vsync_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            dir_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            pending_q <= pending_d;
            vsync_q   <= vsync;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        pending_d = pending_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;

        // Any trigger outside IDLE (DONE included) is remembered as a single pending request.
        if (trig && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (trig || (pending_q && tx_en)) begin
                    state_d   = S_START;
                    pending_d = 1'b0;
                    bit_d     = '0;
                    byte_d    = '0;
                    x_d       = xpos_tank;
                    y_d       = ypos_tank;
                    dir_d     = direction_tank;
                end
            end
            S_START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (byte_q == BYTE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!tx_en) begin
            pending_d = 1'b0;
        end
    end

    // Line level is decoded straight from state so an async reset forces idle-high at once.
    always_comb begin
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_q];
            default: tx = 1'b1;
        endcase
    end

    assign busy     = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign pkt_done = (state_q == S_DONE);

endmodule

// File: doc/tank_state_uart_tx.md
Name: tank_state_uart_tx

Overview:
- Sends the local player's tank state (x/y position, direction) over a UART 8N1 serial line to the opponent board.
- The opponent board's receiver recovers these values and feeds them to its opponent-tank draw path as the opponent's position and direction.
- One packet is sent per video frame, triggered on the rising edge of vsync, using a snapshot of the inputs taken at packet start.
- Sits between the local tank movement logic and the board's UART TX pin.

Parameters:
- CLK_FREQ, 65000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. Bit period DIV = CLK_FREQ/BAUD, integer division, rounded down. DIV >= 2 is required.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-low; asserting it (0) resets all state immediately.
- vsync  in  1  frame sync from the timing chain; its rising edge requests a packet.
- tx_en  in  1  when 1, packets may start; when 0, no new packet starts.
- xpos_tank  in  10  local tank x position.
- ypos_tank  in  10  local tank y position.
- direction_tank  in  2  local tank direction code.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while a packet is in flight.
- pkt_done  out  1  one-cycle pulse after the last stop bit of a packet.

Behaviour:
- Reset (rst=0): tx=1, busy=0, pkt_done=0; FSM=IDLE; baud counter=0; pending=0; vsync_q=0. Reset mid-packet aborts the packet and tx returns to 1 immediately.
- Trigger: vsync_q is vsync registered. A trigger is vsync=1 && vsync_q=0, sampled while tx_en=1.
- Trigger in IDLE:
  - Snapshot xpos, ypos and direction into internal registers.
  - Enter START with busy=1 on the next edge.
  - tx goes low one clock after the edge at which the trigger is sampled.
- Trigger while busy: set pending=1. No queue depth beyond 1; further triggers are absorbed.
- tx_en=0 during a packet: the current packet completes. Pending is cleared.
- Packet bytes:
  - B0 = SYNC_BYTE
  - B1 = xpos[7:0]
  - B2 = {ypos[5:0], xpos[9:8]}
  - B3 = {dir[1:0], 2'b00, ypos[9:6]}
  - B4 = checksum (optional feature only)
- Byte framing: start bit (0), 8 data bits LSB first, one stop bit (1). Each bit lasts exactly DIV clocks. Consecutive bytes follow back-to-back with no idle gap.
- FSM states:
  - IDLE -> START on trigger, or on pending=1 && tx_en=1.
  - START -> DATA after DIV clocks.
  - DATA -> STOP after 8 bits; the bit index counts 0..7.
  - STOP -> START if more bytes remain; otherwise -> DONE.
  - DONE lasts one cycle: pkt_done=1, busy=0, then -> IDLE.
- Baud counter: counts 0..DIV-1, is reloaded to 0 at the start of each bit, and wraps with no drift accumulation within a bit.
- Leaving IDLE because pending=1: pending is cleared and a fresh snapshot is taken at that moment, so the latest values are sent.
- Trigger and DONE in the same cycle: the trigger sets pending, and the next packet starts from IDLE one cycle later.
- Packet length is NBYTES*10*DIV clocks, with NBYTES = 4 or 5. Input changes during a packet have no effect on it.

Optional Feature:
- Macro: TANK_TX_CHECKSUM_EN.
- Defined: 5-byte packet. B4 = B1^B2^B3; SYNC_BYTE is excluded from the XOR.
- Undefined: 4-byte packet, B0..B3 only, with no checksum logic.

Test Plan:
- Reset check: hold rst=0 for 5 cycles, release -> tx=1, busy=0, pkt_done=0; no activity without a vsync edge.
- Single packet:
  - Setup: CLK_FREQ=1000000, BAUD=100000 (DIV=10), tx_en=1, xpos=10'h2AB, ypos=10'h1CD, dir=2'b10, one vsync rise.
  - Required: bytes A5, AB, 36, 87 (+1A with TANK_TX_CHECKSUM_EN).
  - Required: each bit is 10 clocks; busy high for 400/500 clocks; pkt_done pulses once.
- Snapshot: change xpos to 10'h000 mid-packet -> B1 stays 0xAB.
- Pending:
  - Stimulus: second vsync rise during busy, with xpos=10'h001 set before DONE.
  - Required: a second packet starts 1 cycle after DONE; its B1 = 0x01. A third rise inside the same packet adds no extra packet.
- tx_en gating:
  - tx_en=0 at a vsync rise -> no packet; tx stays 1.
  - tx_en dropped mid-packet -> the packet completes; pending is discarded.
- Reset mid-packet: assert rst during DATA of B2 -> tx=1 and busy=0 immediately. The next vsync rise after release sends a complete packet starting with A5.
